// File: rtl/blood_bank_alloc.sv
// blood_bank_alloc
// Donor-unit inventory with a sequential allocator. Units are loaded into the
// lowest free slot. A patient request scans the inventory twice. The first
// pass looks for an exact ABO/Rh match and the second pass accepts any
// compatible unit. The lowest-index qualifying slot is allocated and released.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ld_valid/ld_ready        donor unit load handshake
//   ld_a, ld_b, ld_rh        donor antigens ({a,b}: O=00 B=01 A=10 AB=11), Rh
//   req_valid/req_ready      patient request handshake
//   req_a, req_b, req_rh     patient type and Rh, same encoding
//   rsp_valid/rsp_ready      result handshake
//   rsp_found, rsp_idx       allocation result (idx 0 when not found)
//   units, full              occupied slot count, inventory full flag
module blood_bank_alloc #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic             ld_a,
  input  logic             ld_b,
  input  logic             ld_rh,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_a,
  input  logic             req_b,
  input  logic             req_rh,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_found,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [IDX_W:0]   units,
  output logic             full
);

  typedef enum logic [1:0] {IDLE, SCAN_EX, SCAN_ANY, RESP} state_t;

  state_t           state, state_n;
  logic [DEPTH-1:0] occ;
  logic [DEPTH-1:0] slot_a, slot_b, slot_rh;
  logic             pat_a, pat_b, pat_rh;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] free_idx;
  logic             ld_fire, req_fire;
  logic             scanning, last, cur_compat, cur_exact, hit;

  // A donor antigen the patient lacks, or Rh+ into an Rh- patient, is unsafe.
  function automatic logic compat(input logic da, input logic db, input logic drh,
                                  input logic pa, input logic pb, input logic prh);
    return !(da & !pa) & !(db & !pb) & (!drh | prh);
  endfunction

  function automatic logic exact_match(input logic da, input logic db, input logic drh,
                                       input logic pa, input logic pb, input logic prh);
    return compat(da, db, drh, pa, pb, prh) & (da == pa) & (db == pb) & (drh == prh);
  endfunction

  assign full      = (units == (IDX_W+1)'(DEPTH));
  assign ld_ready  = (state == IDLE) & !full;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign ld_fire   = ld_valid & ld_ready;
  assign req_fire  = req_valid & req_ready;
  assign scanning  = (state == SCAN_EX) | (state == SCAN_ANY);
  assign last      = (ptr == IDX_W'(DEPTH-1));

  assign cur_compat = compat(slot_a[ptr], slot_b[ptr], slot_rh[ptr], pat_a, pat_b, pat_rh);
  assign cur_exact  = exact_match(slot_a[ptr], slot_b[ptr], slot_rh[ptr], pat_a, pat_b, pat_rh);
  assign hit        = scanning & occ[ptr] & ((state == SCAN_EX) ? cur_exact : cur_compat);

  // Descending loop so the lowest free index is the one left standing.
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (!occ[i]) free_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (req_fire) state_n = SCAN_EX;
      SCAN_EX:  if (hit) state_n = RESP;
                else if (last) state_n = SCAN_ANY;
      SCAN_ANY: if (hit || last) state_n = RESP;
      RESP:     if (rsp_ready) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Control: occupancy, count, scan pointer and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= '0;
      units     <= '0;
      ptr       <= '0;
      rsp_found <= 1'b0;
      rsp_idx   <= '0;
    end else begin
      if (ld_fire) begin
        occ[free_idx] <= 1'b1;
        units         <= units + (IDX_W+1)'(1);
      end else if (hit) begin
        occ[ptr] <= 1'b0;
        units    <= units - (IDX_W+1)'(1);
      end

      if (req_fire) begin
        ptr <= '0;
      end else if (scanning && !hit) begin
        ptr <= last ? '0 : ptr + IDX_W'(1);
      end

      if (hit) begin
        rsp_found <= 1'b1;
        rsp_idx   <= ptr;
      end else if ((state == SCAN_ANY) && last) begin
        rsp_found <= 1'b0;
        rsp_idx   <= '0;
      end
    end
  end

  // Data: slot contents and latched patient, qualified by occ / state.
  always_ff @(posedge clk) begin
    if (ld_fire) begin
      slot_a[free_idx]  <= ld_a;
      slot_b[free_idx]  <= ld_b;
      slot_rh[free_idx] <= ld_rh;
    end
    if (req_fire) begin
      pat_a  <= req_a;
      pat_b  <= req_b;
      pat_rh <= req_rh;
    end
  end

endmodule

// File: tb/tb_blood_bank_alloc.sv
module tb_blood_bank_alloc;
  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ld_valid = 1'b0, ld_a = 1'b0, ld_b = 1'b0, ld_rh = 1'b0;
  logic             ld_ready;
  logic             req_valid = 1'b0, req_a = 1'b0, req_b = 1'b0, req_rh = 1'b0;
  logic             req_ready;
  logic             rsp_valid, rsp_found;
  logic             rsp_ready = 1'b0;
  logic [IDX_W-1:0] rsp_idx;
  logic [IDX_W:0]   units;
  logic             full;

  blood_bank_alloc #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a(ld_a), .ld_b(ld_b), .ld_rh(ld_rh),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_rh(req_rh),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_found(rsp_found), .rsp_idx(rsp_idx),
    .units(units), .full(full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int found;
    int idx;
    int lat;
    int units;
    int hs;
  } exp_t;
  exp_t sb[$];

  // Reference inventory: abo = {a,b}, O=0 B=1 A=2 AB=3.
  int m_occ[DEPTH];
  int m_abo[DEPTH];
  int m_rh[DEPTH];
  int m_units = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A donor is acceptable if it carries no antigen the patient lacks, and a
  // Rh-positive donor only goes to a Rh-positive patient.
  function automatic bit fits(input int dabo, input int drh, input int pabo, input int prh);
    return ((dabo & ~pabo & 3) == 0) && (drh == 0 || prh == 1);
  endfunction

  task automatic m_reset();
    for (int s = 0; s < DEPTH; s++) m_occ[s] = 0;
    m_units = 0;
  endtask

  task automatic m_load(input int abo, input int rh);
    bit done = 0;
    for (int s = 0; s < DEPTH; s++) begin
      if (!done && m_occ[s] == 0) begin
        m_occ[s] = 1; m_abo[s] = abo; m_rh[s] = rh; m_units++; done = 1;
      end
    end
  endtask

  task automatic m_alloc(input int pabo, input int prh, output exp_t e);
    e.found = 0; e.idx = 0; e.lat = 2*DEPTH + 1; e.hs = 0;
    for (int s = 0; s < DEPTH; s++) begin
      if (!e.found && m_occ[s] == 1 && m_abo[s] == pabo && m_rh[s] == prh) begin
        e.found = 1; e.idx = s; e.lat = s + 2;
      end
    end
    for (int s = 0; s < DEPTH; s++) begin
      if (!e.found && m_occ[s] == 1 && fits(m_abo[s], m_rh[s], pabo, prh)) begin
        e.found = 1; e.idx = s; e.lat = DEPTH + s + 2;
      end
    end
    if (e.found) begin
      m_occ[e.idx] = 0;
      m_units--;
    end
    e.units = m_units;
  endtask

  // Called at posedge+1 while the DUT is idle.
  task automatic do_load(input int abo, input int rh);
    ld_a = abo[1]; ld_b = abo[0]; ld_rh = rh[0]; ld_valid = 1'b1;
    chk("ld_ready", int'(ld_ready), int'(m_units < DEPTH));
    m_load(abo, rh);
    @(posedge clk); #1;
    ld_valid = 1'b0;
    chk("units_after_load", int'(units), m_units);
    chk("full_after_load", int'(full), int'(m_units == DEPTH));
  endtask

  task automatic do_req(input int pabo, input int prh, input int hold,
                        input int wl, input int labo, input int lrh);
    exp_t e;
    int   n;
    if (wl != 0) begin
      ld_a = labo[1]; ld_b = labo[0]; ld_rh = lrh[0]; ld_valid = 1'b1;
      m_load(labo, lrh);
    end
    rsp_ready = (hold == 0);
    req_a = pabo[1]; req_b = pabo[0]; req_rh = prh[0]; req_valid = 1'b1;
    chk("req_ready_idle", int'(req_ready), 1);
    m_alloc(pabo, prh, e);
    e.hs = cyc;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; ld_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 3*DEPTH) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      sb.delete();
    end else begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        chk("hold_valid", int'(rsp_valid), 1);
        chk("hold_found", int'(rsp_found), e.found);
        chk("hold_idx", int'(rsp_idx), e.idx);
        chk("hold_req_ready", int'(req_ready), 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("idle_after_rsp", int'(req_ready), 1);
      chk("rsp_valid_drop", int'(rsp_valid), 0);
      rsp_ready = 1'b0;
    end
  endtask

  // Scoreboard monitor: compares the first cycle of every response.
  exp_t mon_e;
  bit   seen = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 0;
      end else if (rsp_valid && !seen) begin
        seen = 1;
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_found", int'(rsp_found), mon_e.found);
          chk("rsp_idx", int'(rsp_idx), mon_e.idx);
          chk("rsp_latency", cyc - mon_e.hs, mon_e.lat);
          chk("rsp_units", int'(units), mon_e.units);
        end
      end else if (!rsp_valid) begin
        seen = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int op;

  initial begin
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_found", int'(rsp_found), 0);
    chk("reset_rsp_idx", int'(rsp_idx), 0);
    chk("reset_units", int'(units), 0);
    chk("reset_full", int'(full), 0);
    chk("reset_ld_ready", int'(ld_ready), 1);
    chk("reset_req_ready", int'(req_ready), 1);

    // O+, A-, B+, AB- in slots 0..3
    do_load(0, 1);
    do_load(2, 0);
    do_load(1, 1);
    do_load(3, 0);

    do_req(3, 1, 0, 0, 0, 0);   // AB+ : compatible pass, slot 0, cycle 10
    do_req(2, 0, 0, 0, 0, 0);   // A-  : exact slot 1, cycle 3
    do_req(0, 0, 0, 0, 0, 0);   // O-  : miss, cycle 17

    // Fill remaining six slots with O-, then a ninth load is dropped.
    for (int i = 0; i < 6; i++) do_load(0, 0);
    chk("full_flag", int'(full), 1);
    chk("full_ld_ready", int'(ld_ready), 0);
    do_load(2, 1);

    // A- against a full inventory, consumer stalls for 5 cycles.
    do_req(2, 0, 5, 0, 0, 0);

    // AB+ has no exact unit, so the scan is still running at cycle 4.
    req_a = 1'b1; req_b = 1'b1; req_rh = 1'b1; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_units", int'(units), 0);
    chk("abort_req_ready", int'(req_ready), 1);
    chk("abort_full", int'(full), 0);

    // Load and request O+ together: the new unit is visible to the scan.
    do_req(0, 1, 0, 1, 0, 1);

    for (int it = 0; it < 60; it++) begin
      op = int'($urandom_range(0, 2));
      if (op == 0)
        do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
      else
        do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
